// File: rtl/iterative_comparator.sv
// Multi-cycle magnitude comparator: walks the operands one CHUNK at a time,
// MSB chunk first, and stops at the first chunk that differs.
// WIDTH must be an integer multiple of CHUNK.
module iterative_comparator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SH_W  = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sgn_q, sgn_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;

    logic [SH_W-1:0]    shamt_c;
    logic [CHUNK-1:0]   a_chunk_c;
    logic [CHUNK-1:0]   b_chunk_c;
    logic               first_c;
    logic               sign_split_c;

    // Select the chunk addressed by idx_q and detect the signed fast path
    always_comb begin
        shamt_c      = SH_W'(idx_q) * SH_W'(CHUNK);
        a_chunk_c    = CHUNK'(a_q >> shamt_c);
        b_chunk_c    = CHUNK'(b_q >> shamt_c);
        first_c      = (idx_q == IDX_W'(N - 1));
        sign_split_c = sgn_q && (a_q[WIDTH-1] != b_q[WIDTH-1]);
    end

    // Next-state, operand capture and result decision
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = is_signed;
                    idx_d   = IDX_W'(N - 1);
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (first_c && sign_split_c) begin
                    // Negative operand is the smaller one regardless of magnitude
                    lt_d    = a_q[WIDTH-1];
                    gt_d    = ~a_q[WIDTH-1];
                    eq_d    = 1'b0;
                    state_d = S_DONE;
                end else if (a_chunk_c != b_chunk_c) begin
                    lt_d    = (a_chunk_c < b_chunk_c);
                    gt_d    = (a_chunk_c > b_chunk_c);
                    eq_d    = 1'b0;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign lt    = lt_q;
    assign eq    = eq_q;
    assign gt    = gt_q;

endmodule

// File: tb/tb_iterative_comparator.sv
// Directed bench for iterative_comparator with a scoreboard of expected
// results; a second instance covers the single-chunk configuration.
module tb_iterative_comparator;

    logic        clock;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        done;
    logic        lt;
    logic        eq;
    logic        gt;

    logic        start2;
    logic        is_signed2;
    logic [15:0] a2;
    logic [15:0] b2;
    logic        ready2;
    logic        done2;
    logic        lt2;
    logic        eq2;
    logic        gt2;

    typedef struct packed {
        logic       lt;
        logic       eq;
        logic       gt;
        logic [7:0] k;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;
    int   since_e0;

    iterative_comparator #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .done      (done),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt)
    );

    iterative_comparator #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clock     (clock),
        .reset     (reset),
        .start     (start2),
        .is_signed (is_signed2),
        .a         (a2),
        .b         (b2),
        .ready     (ready2),
        .done      (done2),
        .lt        (lt2),
        .eq        (eq2),
        .gt        (gt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One rising edge, then settle before sampling
    task automatic tick();
        @(posedge clock);
        #1;
        since_e0++;
    endtask

    // Drive a start request so that the next rising edge is E0
    task automatic issue(input logic sgn, input logic [31:0] aa, input logic [31:0] bb,
                         input logic push, input logic elt, input logic eeq,
                         input logic egt, input logic [7:0] ek);
        exp_t e;
        @(negedge clock);
        start     = 1'b1;
        is_signed = sgn;
        a         = aa;
        b         = bb;
        if (push) begin
            e.lt = elt; e.eq = eeq; e.gt = egt; e.k = ek;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        since_e0 = 0;
        start    = 1'b0;
    endtask

    // Wait (bounded) for done, compare against the scoreboard head
    task automatic wait_result(input string tag, input logic post_check);
        exp_t e;
        int   guard;
        guard = 0;
        while (!done && guard < 40) begin
            tick();
            guard++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        if (done) begin
            if (exp_q.size() == 0) begin
                check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_lt"}, 32'(lt), 32'(e.lt));
                check({tag, "_eq"}, 32'(eq), 32'(e.eq));
                check({tag, "_gt"}, 32'(gt), 32'(e.gt));
                // done is high after decision edge k, i.e. sampled by edge k+1
                check({tag, "_latency"}, 32'(since_e0), 32'(e.k));
                check({tag, "_ready_low"}, 32'(ready), 32'd0);
            end
            if (post_check) begin
                tick();
                check({tag, "_done_pulse"}, 32'(done), 32'd0);
                check({tag, "_ready_back"}, 32'(ready), 32'd1);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        since_e0   = 0;
        reset      = 1'b1;
        start      = 1'b0;
        is_signed  = 1'b0;
        a          = '0;
        b          = '0;
        start2     = 1'b0;
        is_signed2 = 1'b0;
        a2         = '0;
        b2         = '0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done",  32'(done),  32'd0);
        check("rst_flags", {29'd0, lt, eq, gt}, 32'd0);
        check("rst_ready16", 32'(ready2), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        // Signed: -1 < 1 decided on the sign bits at k=1
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        wait_result("s_neg1_vs_1", 1'b1);

        // Unsigned: same operands, top chunk FF > 00 at k=1
        issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        wait_result("u_ff_vs_1", 1'b1);

        // Signed, equal signs, differ only in last chunk
        issue(1'b1, 32'h1234_5677, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
        wait_result("s_last_chunk", 1'b1);

        // Equal operands in both modes run all four chunks
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
        wait_result("s_eq", 1'b1);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4);
        wait_result("u_eq", 1'b1);

        // Early exit in a middle chunk
        issue(1'b0, 32'h0130_0000, 32'h0120_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
        wait_result("u_mid_chunk", 1'b1);

        // Start during COMPARE with new operands must be ignored
        issue(1'b0, 32'h0102_0304, 32'h0102_0305, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
        @(negedge clock);
        start = 1'b1;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0000_0000;
        tick();
        @(negedge clock);
        start = 1'b0;
        wait_result("busy_start", 1'b0);
        // Start during the DONE cycle must also be ignored
        @(negedge clock);
        start = 1'b1;
        a     = 32'h0000_0000;
        b     = 32'hFFFF_FFFF;
        tick();
        check("done_start_ready", 32'(ready), 32'd1);
        check("done_start_done",  32'(done),  32'd0);
        @(negedge clock);
        start = 1'b0;
        tick();
        check("done_start_ignored", 32'(ready), 32'd1);
        check("done_start_flags", {29'd0, lt, eq, gt}, 32'b100);

        // Reset at k=2 abandons the operation
        issue(1'b0, 32'h1122_3344, 32'h1122_3355, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("rst_mid_done",  32'(done),  32'd0);
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_flags", {29'd0, lt, eq, gt}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
            tick();
            check("rst_mid_no_done", 32'(done), 32'd0);
        end
        issue(1'b0, 32'd5, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4);
        wait_result("after_rst_5_vs_3", 1'b1);

        // Single-chunk instance: always decided at k=1
        @(negedge clock);
        start2     = 1'b1;
        is_signed2 = 1'b1;
        a2         = 16'h8000;
        b2         = 16'h7FFF;
        @(posedge clock);
        #1;
        start2 = 1'b0;
        check("w16_busy", 32'(ready2), 32'd0);
        tick();
        check("w16_done",  32'(done2), 32'd1);
        check("w16_flags", {29'd0, lt2, eq2, gt2}, 32'b100);
        tick();
        check("w16_done_pulse", 32'(done2),  32'd0);
        check("w16_ready_back", 32'(ready2), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
